// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_ctrl instruction sequencer: opcode encoding,
// FSM state encodings and the default reset PC.
package cpu_pkg;

    localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_JZ   = 3'b001,
        OP_ADD  = 3'b010,
        OP_AND  = 3'b011,
        OP_XOR  = 3'b100,
        OP_MOV  = 3'b101,
        OP_LDI  = 3'b110,
        OP_HALT = 3'b111
    } op_e;

    // FSM state enumeration, kept as plain constants for legacy tools.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_OPER   = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    function automatic logic is_two_byte(input op_e op);
        return (op == OP_JZ) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction-fetch and register-file/ALU control bundle between cpu_ctrl
// (master) and the datapath/memory side (slave).
interface cpu_ctrl_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_rdata;
    logic       is_zero;
    logic [1:0] rf_ra;
    logic [1:0] rf_rb;
    logic       rf_we;
    logic [1:0] rf_wa;
    logic [2:0] alu_op;
    logic       imm_sel;
    logic [7:0] imm;

    modport master (
        output imem_req, imem_addr, rf_ra, rf_rb, rf_we, rf_wa, alu_op, imm_sel, imm,
        input  imem_valid, imem_rdata, is_zero
    );

    modport slave (
        input  imem_req, imem_addr, rf_ra, rf_rb, rf_we, rf_wa, alu_op, imm_sel, imm,
        output imem_valid, imem_rdata, is_zero
    );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction-byte decoder: op=[7:5], ra=[4:3], rb=[2:1]; bit 0 unused.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output op_e        op,
    output logic [1:0] ra,
    output logic [1:0] rb,
    output logic       two_byte
);
    logic ir_bit0_unused;

    assign op             = op_e'(ir[7:5]);
    assign ra             = ir[4:3];
    assign rb             = ir[2:1];
    assign two_byte       = is_two_byte(op);
    assign ir_bit0_unused = ir[0];
endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer for an 8-bit, 4-register accumulator-style CPU.
// Optional retired-instruction counter enabled by defining CPU_CTRL_PERF_EN.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    cpu_ctrl_if.master bus,
    output logic [7:0] pc,
    output logic       halted
`ifdef CPU_CTRL_PERF_EN
    ,
    output logic [15:0] retired
`endif
);
    logic [2:0] state;
    logic [7:0] ir;
    logic [7:0] imm_q;
    op_e        op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       two_byte;
    logic       fetch_phase;

    cpu_ctrl_decode u_decode (
        .ir       (ir),
        .op       (op),
        .ra       (ra),
        .rb       (rb),
        .two_byte (two_byte)
    );

    assign fetch_phase = (state == ST_FETCH) || (state == ST_OPER);
    assign halted      = (state == ST_HALT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            imm_q <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.imem_valid) begin
                        ir    <= bus.imem_rdata;
                        pc    <= pc + 8'd1;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (two_byte)             state <= ST_OPER;
                    else if (op == OP_HALT)   state <= ST_HALT;
                    else if (op == OP_NOP)    state <= ST_FETCH;
                    else                      state <= ST_EXEC;
                end
                ST_OPER: begin
                    if (bus.imem_valid) begin
                        imm_q <= bus.imem_rdata;
                        pc    <= pc + 8'd1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op == OP_JZ && bus.is_zero) pc <= imm_q;
                    state <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        bus.imem_req  = fetch_phase;
        bus.imem_addr = pc;
        bus.rf_ra     = ra;
        bus.rf_rb     = rb;
        bus.rf_wa     = ra;
        bus.imm       = imm_q;
        bus.alu_op    = 3'b000;
        bus.imm_sel   = 1'b0;
        bus.rf_we     = 1'b0;
        if (state == ST_EXEC) begin
            unique case (op)
                OP_ADD, OP_AND, OP_XOR, OP_MOV: begin
                    bus.alu_op = op;
                    bus.rf_we  = 1'b1;
                end
                OP_LDI: begin
                    // Immediate load reuses the MOV datapath with rs2 taken from imm.
                    bus.alu_op  = OP_MOV;
                    bus.imm_sel = 1'b1;
                    bus.rf_we   = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_CTRL_PERF_EN
    logic retire;

    // NOP and HALT complete in DECODE; everything else completes in EXEC.
    assign retire = (state == ST_EXEC) ||
                    ((state == ST_DECODE) && (op == OP_NOP || op == OP_HALT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire && retired != 16'hFFFF) begin
            retired <= retired + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction vector table, register-write
// scoreboard, and hand-written reset / wait-state / HALT / wrap sequences.
module tb_cpu_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc;
    logic       halted;
`ifdef CPU_CTRL_PERF_EN
    logic [15:0] retired;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] pc_m = 8'h00;

    cpu_ctrl_if bus ();

    cpu_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
`ifdef CPU_CTRL_PERF_EN
        ,
        .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Expected register-file writes, pushed when the instruction is driven.
    typedef struct packed {
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] wa;
        logic [2:0] op;
        logic       isel;
        logic [7:0] imm;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rf_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_ra", {30'd0, bus.rf_ra}, {30'd0, mon_e.ra});
                    check("wr_rb", {30'd0, bus.rf_rb}, {30'd0, mon_e.rb});
                    check("wr_wa", {30'd0, bus.rf_wa}, {30'd0, mon_e.wa});
                    check("wr_alu_op", {29'd0, bus.alu_op}, {29'd0, mon_e.op});
                    check("wr_imm_sel", {31'd0, bus.imm_sel}, {31'd0, mon_e.isel});
                    if (mon_e.isel) check("wr_imm", {24'd0, bus.imm}, {24'd0, mon_e.imm});
                end
            end else begin
                check("quiet_alu", {28'd0, bus.alu_op, bus.imm_sel}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 8'h00;
        bus.is_zero    = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pc_m = 8'h00;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req"}, {31'd0, bus.imem_req}, 32'd1);
    endtask

    // Answer one fetch at the expected address after 'waits' stall cycles.
    task automatic serve(input string name, input logic [7:0] addr,
                         input logic [7:0] data, input int waits);
        wait_req(name);
        check({name, "_addr"}, {24'd0, bus.imem_addr}, {24'd0, addr});
        for (int i = 0; i < waits; i++) begin
            bus.imem_valid = 1'b0;
            @(negedge clk);
            check({name, "_hold"}, {23'd0, bus.imem_req, bus.imem_addr}, {23'd0, 1'b1, addr});
        end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 8'h00;
    endtask

    typedef struct {
        string      name;
        logic [7:0] b1;
        logic [7:0] b2;
        int         waits;
        logic       z;
        logic       rstb;
        logic       we;
        logic [2:0] op;
        logic       isel;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] wa;
        logic [7:0] imm;
        logic [7:0] npc;
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input vec_t v);
        logic two;
        two = (v.b1[7:5] == 3'b001) || (v.b1[7:5] == 3'b110);
        if (v.rstb) do_reset();
        bus.is_zero = v.z;
        if (v.we) sb.push_back('{ra: v.ra, rb: v.rb, wa: v.wa, op: v.op, isel: v.isel, imm: v.imm});
        serve(v.name, pc_m, v.b1, 0);
        pc_m = pc_m + 8'd1;
        if (two) begin
            serve({v.name, "_b2"}, pc_m, v.b2, v.waits);
            pc_m = pc_m + 8'd1;
        end
        wait_req({v.name, "_next"});
        check({v.name, "_next_addr"}, {24'd0, bus.imem_addr}, {24'd0, v.npc});
        check({v.name, "_pc"}, {24'd0, pc}, {24'd0, v.npc});
        pc_m = v.npc;
    endtask

    initial begin
        logic flag;
        //           name        b1     b2     w  z  rst we op      is ra rb wa imm    npc
        vecs[0]  = '{"add",      8'h4A, 8'h00, 0, 0, 1, 1, 3'b010, 0, 1, 1, 1, 8'h00, 8'h01};
        vecs[1]  = '{"ldi",      8'hD0, 8'h5A, 3, 0, 1, 1, 3'b101, 1, 2, 0, 2, 8'h5A, 8'h02};
        vecs[2]  = '{"xor",      8'h9C, 8'h00, 0, 0, 0, 1, 3'b100, 0, 3, 2, 3, 8'h00, 8'h03};
        vecs[3]  = '{"and",      8'h67, 8'h00, 0, 0, 0, 1, 3'b011, 0, 0, 3, 0, 8'h00, 8'h04};
        vecs[4]  = '{"mov",      8'hB2, 8'h00, 0, 0, 0, 1, 3'b101, 0, 2, 1, 2, 8'h00, 8'h05};
        vecs[5]  = '{"nop",      8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 8'h00, 8'h06};
        vecs[6]  = '{"jz_taken", 8'h20, 8'h40, 0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 8'h00, 8'h40};
        vecs[7]  = '{"jz_not",   8'h20, 8'h40, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 8'h00, 8'h02};
        vecs[8]  = '{"add2",     8'h56, 8'h00, 0, 0, 0, 1, 3'b010, 0, 2, 3, 2, 8'h00, 8'h03};
        vecs[9]  = '{"jz_to_ff", 8'h20, 8'hFF, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 8'h00, 8'hFF};
        vecs[10] = '{"ldi_wrap", 8'hD8, 8'hA5, 2, 0, 0, 1, 3'b101, 1, 3, 0, 3, 8'hA5, 8'h01};

        // Reset state, one IDLE cycle, then fetch at 0 with valid tied high.
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 8'h00;
        bus.is_zero    = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_pc", {24'd0, pc}, 32'h00);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_we", {31'd0, bus.rf_we}, 32'd0);
        check("rst_imm", {24'd0, bus.imm}, 32'h00);
        rst = 1'b0;
        #1;
        check("idle_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", {24'd0, bus.imem_addr}, 32'h00);
        @(negedge clk);
        check("first_capture_pc", {24'd0, pc}, 32'h01);
        bus.imem_valid = 1'b0;

        // Reset mid-fetch: request drops at once and a late valid is ignored.
        do_reset();
        @(negedge clk);
        check("midfetch_req", {31'd0, bus.imem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midfetch_rst_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 8'h4A;
        @(negedge clk);
        check("midfetch_rst_pc", {24'd0, pc}, 32'h00);
        rst = 1'b0;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        check("late_valid_pc", {24'd0, pc}, 32'h00);
        check("late_valid_req", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clk);
        check("late_valid_still_fetch", {24'd0, pc}, 32'h00);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // HALT fetched at 8'hFF: pc wraps, controller parks until reset.
        do_reset();
        bus.is_zero = 1'b1;
        serve("halt_jz", 8'h00, 8'h20, 0);
        serve("halt_jz_b2", 8'h01, 8'hFF, 0);
        serve("halt", 8'hFF, 8'hE0, 0);
        @(negedge clk);
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_pc", {24'd0, pc}, 32'h00);
        flag = 1'b0;
        bus.imem_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req || !halted || bus.rf_we) flag = 1'b1;
        end
        bus.imem_valid = 1'b0;
        check("halt_hold", {31'd0, flag}, 32'd0);
        do_reset();
        check("restart_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check("restart_req", {31'd0, bus.imem_req}, 32'd1);
        check("restart_addr", {24'd0, bus.imem_addr}, 32'h00);

`ifdef CPU_CTRL_PERF_EN
        do_reset();
        serve("perf_nop", 8'h00, 8'h00, 0);
        sb.push_back('{ra: 2'd1, rb: 2'd1, wa: 2'd1, op: 3'b010, isel: 1'b0, imm: 8'h00});
        serve("perf_add", 8'h01, 8'h4A, 0);
        serve("perf_halt", 8'h02, 8'hE0, 0);
        repeat (3) @(negedge clk);
        check("perf_retired", {16'd0, retired}, 32'd3);
`endif

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
